fpcvt_sched: RTL and testbench
==============================

Name: fpcvt_sched

Overview:
Round-robin scheduler and sequencer that shares one serial linear-to-float conversion datapath among NREQ requesters. Each request is a 12-bit two's-complement sample. The block produces a sign bit, a 3-bit exponent and a 4-bit significand, with value = F × 2^E. Normalisation is one shift per cycle, followed by a round step. The block sits between the sample sources and the downstream float consumer.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, derived localparam = clog2(NREQ), minimum 1; width of out_id.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  per-requester request valid.
req_data  in  12*NREQ  per-requester sample; requester i uses bits [12i+11:12i].
req_ready  out  NREQ  one-hot acceptance pulse, 1 cycle.
out_valid  out  1  result valid.
out_ready  in  1  consumer ready.
out_s  out  1  sign.
out_e  out  3  exponent.
out_f  out  4  significand.
out_id  out  IDW  index of the requester that owns the result.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: async clear. State goes to IDLE. All outputs go to 0. RR pointer goes to NREQ-1, so requester 0 has first priority. Any in-flight conversion is discarded; no partial result is emitted.
- Requester protocol: req_valid and req_data are held stable until req_ready is seen. A requester may drop req_valid before it is granted.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - If any req_valid is high, grant the first valid index searching from ptr+1 upward, wrapping modulo NREQ.
  - req_ready[g] is 1 for that cycle only. ptr becomes g.
  - Capture s = D[11] and mag = |D| as 11 bits. D = -2048 saturates mag to 2047.
  - Load shreg = mag and e = 7. Go to NORM.
  - req_ready is never asserted outside IDLE.
- NORM, evaluated each cycle:
  - If shreg[10] = 1 or e = 0, go to ROUND with no shift.
  - Otherwise shreg <<= 1 (zero fill) and e -= 1.
  - NORM occupies k+1 cycles, where k = 7 - final e.
- ROUND:
  - f = shreg[10:7], r = shreg[6].
  - If r = 0: F = f.
  - If r = 1 and f < 15: F = f+1.
  - If r = 1 and f = 15 and e < 7: F = 8, E = e+1.
  - If r = 1 and f = 15 and e = 7: saturate to F = 15, E = 7.
  - Register out_s, out_e, out_f and out_id. Go to DONE.
- DONE:
  - out_valid = 1. All out_* fields stay stable until out_ready.
  - On out_valid & out_ready, clear out_valid and go to IDLE. The next grant happens no earlier than the following cycle.
- Latency: acceptance at cycle 0 gives out_valid at cycle k+3. Best case 3 cycles; worst case 10 cycles (k = 7).
- Zero input gives S=0, E=0, F=0 after 7 shifts.
- A new req_valid that arrives while busy waits; there is no pre-emption.
- A simultaneous request and reset deassertion is not granted until the first clock edge after rst_n rises.
- Arithmetic: shreg is 11 bits and e is 3 bits, with no wrap. The e = 0 check is what prevents wrap.

Test Plan:
- Reset, then only req 0 with D=0x1A6 (422) -> req_ready[0] at cycle 0, out_valid at cycle 5, S=0, E=5, F=0b1101, id=0.
- Req 2 with D=0xE5A (-422) -> S=1, E=5, F=0b1101, id=2; hold out_ready=0 for 4 cycles and check the outputs stay stable and no new req_ready fires.
- Rounding: D=0x0F8 -> S=0, E=5, F=0b1000. D=0x7FF -> S=0, E=7, F=0b1111 (saturate). D=0x800 -> S=1, E=7, F=0b1111. D=0x000 -> S=0, E=0, F=0 at cycle 10. D=0x008 -> E=0, F=0b1000.
- Fairness: all four req_valid held from reset, out_ready=1 -> grant order 0,1,2,3. Then reqs 1 and 3 pending with ptr=3 -> grant 1 before 3.
- Mid-operation reset: assert rst_n=0 during NORM -> out_valid, req_ready and busy go to 0 immediately (asynchronously). After release, the next grant goes to the lowest valid index.
- Req withdrawn: req 1 drops req_valid while req 0 is being converted -> no grant is given to 1.

Source files
------------

// File: rtl/fpcvt_sched.sv
// fpcvt_sched: round-robin scheduler sharing one serial 12-bit linear to
// sign/3-bit exponent/4-bit significand float converter among NREQ requesters.
module fpcvt_sched #(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [12*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_s,
  output logic [2:0]           out_e,
  output logic [3:0]           out_f,
  output logic [IDW-1:0]       out_id,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, out_id_q, out_id_d, gnt;
  logic s_q, s_d, out_s_q, out_s_d, gnt_vld, r;
  logic [10:0] sh_q, sh_d;
  logic [2:0] e_q, e_d, out_e_q, out_e_d;
  logic [3:0] out_f_q, out_f_d, f;
  logic [11:0] din;
  // first valid requester after ptr, wrapping; later writes win so smallest offset is kept
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    din = '0;
    for (int i = NREQ; i >= 1; i--)
      for (int j = 0; j < NREQ; j++)
        if ((int'(ptr_q) + i) % NREQ == j && req_valid[j]) begin
          gnt = IDW'(j);
          gnt_vld = 1'b1;
        end
    for (int j = 0; j < NREQ; j++)
      if (gnt == IDW'(j)) din = req_data[12*j +: 12];
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    s_d = s_q;
    sh_d = sh_q;
    e_d = e_q;
    out_s_d = out_s_q;
    out_e_d = out_e_q;
    out_f_d = out_f_q;
    out_id_d = out_id_q;
    f = sh_q[10:7];
    r = sh_q[6];
    for (int j = 0; j < NREQ; j++)
      req_ready[j] = rst_n && state_q == IDLE && gnt_vld && gnt == IDW'(j);
    case (state_q)
      IDLE: if (gnt_vld && rst_n) begin
        ptr_d = gnt;
        id_d = gnt;
        s_d = din[11];
        sh_d = (din == 12'h800) ? 11'h7ff : din[11] ? 11'(-din) : din[10:0];
        e_d = 3'd7;
        state_d = NORM;
      end
      NORM: if (sh_q[10] || e_q == 3'd0) state_d = ROUND;
        else begin
          sh_d = {sh_q[9:0], 1'b0};
          e_d = e_q - 3'd1;
        end
      ROUND: begin
        out_s_d = s_q;
        out_id_d = id_q;
        out_f_d = !r ? f : (f != 4'hf) ? f + 4'd1 : (e_q != 3'd7) ? 4'd8 : 4'hf;
        out_e_d = (r && f == 4'hf && e_q != 3'd7) ? e_q + 3'd1 : e_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= IDW'(NREQ - 1);
      id_q <= '0;
      s_q <= 1'b0;
      sh_q <= '0;
      e_q <= '0;
      out_s_q <= 1'b0;
      out_e_q <= '0;
      out_f_q <= '0;
      out_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      s_q <= s_d;
      sh_q <= sh_d;
      e_q <= e_d;
      out_s_q <= out_s_d;
      out_e_q <= out_e_d;
      out_f_q <= out_f_d;
      out_id_q <= out_id_d;
    end
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_s = out_s_q;
  assign out_e = out_e_q;
  assign out_f = out_f_q;
  assign out_id = out_id_q;
endmodule

// File: tb/tb_fpcvt_sched.sv
// tb_fpcvt_sched: randomized and directed bench for fpcvt_sched with a
// cycle-level behavioural reference model checked on every falling edge.
module tb_fpcvt_sched;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst_n;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [12*NREQ-1:0] req_data;
  logic out_valid, out_ready, out_s, busy;
  logic [2:0] out_e;
  logic [3:0] out_f;
  logic [1:0] out_id;
  int n_chk = 0, n_fail = 0;

  fpcvt_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // value = F * 2^E with F the rounded top four significant bits of |D|
  function automatic void conv(input logic [11:0] d, output int s, output int e,
                               output int f, output int k);
    int v, m, p;
    v = int'($signed(d));
    s = int'(d[11]);
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    p = -1;
    for (int b = 0; b < 11; b++) if (((m >> b) & 1) == 1) p = b;
    e = (p > 3) ? p - 3 : 0;
    k = 7 - e;
    f = (e > 0) ? (m + (1 << (e - 1))) >> e : m;
    if (f == 16) begin
      if (e < 7) begin f = 8; e++; end
      else f = 15;
    end
  endfunction

  int m_st = 0, m_ptr = NREQ - 1, m_wait = 0, ms = 0, me = 0, mf = 0, mid = 0;
  always @(negedge clk) begin
    int g, k;
    logic [NREQ-1:0] exp_rr;
    if (!rst_n) begin
      m_st = 0; m_ptr = NREQ - 1; ms = 0; me = 0; mf = 0; mid = 0;
      chk("rst_outputs", int'({req_ready, out_valid, busy, out_s, out_e, out_f, out_id}), 0);
    end else begin
      g = -1;
      exp_rr = '0;
      if (m_st == 0)
        for (int i = 1; i <= NREQ; i++)
          if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      if (g >= 0) exp_rr[g] = 1'b1;
      chk("m_req_ready", int'(req_ready), int'(exp_rr));
      chk("m_busy", int'(busy), int'(m_st != 0));
      chk("m_out_valid", int'(out_valid), int'(m_st == 2));
      if (m_st == 2) begin
        chk("m_out_s", int'(out_s), ms);
        chk("m_out_e", int'(out_e), me);
        chk("m_out_f", int'(out_f), mf);
        chk("m_out_id", int'(out_id), mid);
      end
      if (g >= 0) begin
        conv(req_data[12*g +: 12], ms, me, mf, k);
        mid = g; m_ptr = g; m_st = 1; m_wait = k + 2;
      end else if (m_st == 1) begin
        m_wait--;
        if (m_wait == 0) m_st = 2;
      end else if (m_st == 2 && out_ready) m_st = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic one(input int id, input logic [11:0] d, input int elat,
                     input int es, input int ee, input int ef);
    int lat;
    req_data[12*id +: 12] = d;
    req_valid[id] = 1'b1;
    @(negedge clk);
    chk("grant", int'(req_ready), 1 << id);
    cyc();
    req_valid[id] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    chk("latency", lat, elat);
    chk("out_s", int'(out_s), es);
    chk("out_e", int'(out_e), ee);
    chk("out_f", int'(out_f), ef);
    chk("out_id", int'(out_id), id);
  endtask

  task automatic wait_grant(input int g);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 30);
    chk("grant_order", int'(req_ready), 1 << g);
    cyc();
    req_valid[g] = 1'b0;
  endtask

  task automatic idle_wait();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 40);
    chk("idle_timeout", int'(busy), 0);
    cyc();
  endtask

  function automatic logic [11:0] rnd_d();
    case ($urandom_range(0, 6))
      0: return 12'h800;
      1: return 12'h7ff;
      2: return 12'($urandom_range(0, 15));
      3: return 12'h0f8;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    int cnt;
    logic [NREQ-1:0] gr;
    rst_n = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    one(0, 12'h1a6, 5, 0, 5, 13); cyc();
    out_ready = 1'b0;
    one(2, 12'he5a, 5, 1, 5, 13);
    req_data[23:12] = 12'h123;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_no_grant", int'(req_ready), 0);
      chk("hold_fields", int'({out_s, out_e, out_f, out_id}), int'({1'b1, 3'd5, 4'd13, 2'd2}));
    end
    cyc();
    req_valid[1] = 1'b0;
    out_ready = 1'b1;
    cyc();
    one(0, 12'h0f8, 6, 0, 5, 8); cyc();
    one(0, 12'h7ff, 3, 0, 7, 15); cyc();
    one(0, 12'h800, 3, 1, 7, 15); cyc();
    one(0, 12'h000, 10, 0, 0, 0); cyc();
    one(0, 12'h008, 10, 0, 0, 8); cyc();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[12*i +: 12] = 12'(100 * i + 7);
    req_valid = '1;
    cyc();
    rst_n = 1'b1;
    for (int g = 0; g < NREQ; g++) wait_grant(g);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    wait_grant(1);
    wait_grant(3);
    idle_wait();
    req_data[35:24] = 12'h001;
    req_valid[2] = 1'b1;
    wait_grant(2);
    cyc();
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_req_ready", int'(req_ready), 0);
    cyc();
    rst_n = 1'b1;
    wait_grant(1);
    wait_grant(3);
    idle_wait();
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    wait_grant(0);
    req_valid[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (req_ready[1]) cnt++;
    end
    chk("withdrawn_no_grant", cnt, 0);
    cyc();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gr = req_ready;
      cyc();
      for (int i = 0; i < NREQ; i++)
        if (gr[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_data[12*i +: 12] = rnd_d();
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) req_valid[i] = 1'b0;
      out_ready = $urandom_range(0, 3) != 0;
      if (c == 1500) rst_n = 1'b0;
      if (c == 1501) rst_n = 1'b1;
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (15) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
